// File: rtl/bram_port_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM, with tagged read return.
// Optional address range checking is enabled by defining BRAM_ARB_RANGE_CHECK_EN.
module bram_port_arbiter #(
  parameter int unsigned C_MEMSIZE     = 'h4000,
  parameter int unsigned C_PORT_AWIDTH = 32,
  parameter int unsigned C_PORT_DWIDTH = 32,
  parameter int unsigned C_NUM_WE      = 4
) (
  input  logic                     BRAM_Clk,
  input  logic                     BRAM_Rst_N,
  input  logic                     Req_0,
  input  logic                     Req_1,
  input  logic [0:C_PORT_AWIDTH-1] Addr_0,
  input  logic [0:C_PORT_AWIDTH-1] Addr_1,
  input  logic [0:C_NUM_WE-1]      We_0,
  input  logic [0:C_NUM_WE-1]      We_1,
  input  logic [0:C_PORT_DWIDTH-1] Wdata_0,
  input  logic [0:C_PORT_DWIDTH-1] Wdata_1,
  output logic                     Ack_0,
  output logic                     Ack_1,
  output logic [0:C_PORT_DWIDTH-1] Rdata_0,
  output logic [0:C_PORT_DWIDTH-1] Rdata_1,
  output logic                     Rvalid_0,
  output logic                     Rvalid_1,
  output logic                     Err_0,
  output logic                     Err_1,
  output logic                     BRAM_EN,
  output logic [0:C_NUM_WE-1]      BRAM_WEN,
  output logic [0:C_PORT_AWIDTH-1] BRAM_Addr,
  output logic [0:C_PORT_DWIDTH-1] BRAM_Dout,
  input  logic [0:C_PORT_DWIDTH-1] BRAM_Din
);

  localparam int unsigned AW = C_PORT_AWIDTH;
  localparam int unsigned DW = C_PORT_DWIDTH;
  localparam int unsigned NW = C_NUM_WE;
  localparam logic [0:AW-1] ALIGN_MASK = ~AW'(3);

  logic          last_grant;   // 1 = requester 1 was granted last
  logic          grant_0;
  logic          grant_1;
  logic          any_grant;
  logic          issue;
  logic          oor_c;
  logic [0:AW-1] sel_addr;
  logic [0:NW-1] sel_we;
  logic [0:DW-1] sel_wdata;
  logic          sel_rd;
  logic          s1_rd;
  logic          s1_id;
  logic [0:DW-1] hold_0;
  logic [0:DW-1] hold_1;

  // Round-robin: on a tie the requester not granted last wins.
  assign grant_0   = Req_0 && (!Req_1 || last_grant);
  assign grant_1   = Req_1 && (!Req_0 || !last_grant);
  assign Ack_0     = BRAM_Rst_N && grant_0;
  assign Ack_1     = BRAM_Rst_N && grant_1;
  assign any_grant = Ack_0 || Ack_1;
  assign issue     = any_grant && !oor_c;

  always_comb begin
    sel_addr  = Addr_0;
    sel_we    = We_0;
    sel_wdata = Wdata_0;
    if (grant_1) begin
      sel_addr  = Addr_1;
      sel_we    = We_1;
      sel_wdata = Wdata_1;
    end
    sel_rd = (sel_we == '0);
  end

`ifdef BRAM_ARB_RANGE_CHECK_EN
  localparam logic [0:AW-1] MEM_LIMIT = AW'(C_MEMSIZE);
  logic s1_oor;

  assign oor_c = (sel_addr >= MEM_LIMIT);

  // Out-of-range accesses are acked, never issued, and flagged two cycles after grant.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      s1_oor <= 1'b0;
      Err_0  <= 1'b0;
      Err_1  <= 1'b0;
    end else begin
      s1_oor <= any_grant && oor_c;
      Err_0  <= s1_oor && !s1_id;
      Err_1  <= s1_oor && s1_id;
    end
  end
`else
  assign oor_c = 1'b0;
  assign Err_0 = 1'b0;
  assign Err_1 = 1'b0;
`endif

  // Command stage, return tags, and read-data hold registers.
  always_ff @(posedge BRAM_Clk or negedge BRAM_Rst_N) begin
    if (!BRAM_Rst_N) begin
      last_grant <= 1'b1;
      BRAM_EN    <= 1'b0;
      BRAM_WEN   <= '0;
      BRAM_Addr  <= '0;
      BRAM_Dout  <= '0;
      s1_rd      <= 1'b0;
      s1_id      <= 1'b0;
      Rvalid_0   <= 1'b0;
      Rvalid_1   <= 1'b0;
      hold_0     <= '0;
      hold_1     <= '0;
    end else begin
      if (any_grant) last_grant <= grant_1;
      BRAM_EN  <= issue;
      BRAM_WEN <= issue ? sel_we : '0;
      if (issue) begin
        BRAM_Addr <= sel_addr & ALIGN_MASK;
        BRAM_Dout <= sel_wdata;
      end
      s1_rd    <= any_grant && sel_rd;
      s1_id    <= grant_1;
      Rvalid_0 <= s1_rd && !s1_id;
      Rvalid_1 <= s1_rd && s1_id;
      if (Rvalid_0) hold_0 <= Rdata_0;
      if (Rvalid_1) hold_1 <= Rdata_1;
    end
  end

  // BRAM_Din is only valid in the return cycle, so read data passes through then and is held after.
  assign Rdata_0 = Rvalid_0 ? (Err_0 ? '0 : BRAM_Din) : hold_0;
  assign Rdata_1 = Rvalid_1 ? (Err_1 ? '0 : BRAM_Din) : hold_1;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed self-checking bench for bram_port_arbiter with a one-cycle-latency BRAM model.
// Expectations follow BRAM_ARB_RANGE_CHECK_EN when it is defined.
module tb_bram_port_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_0, req_1;
  logic [0:31] addr_0, addr_1;
  logic [0:3]  we_0, we_1;
  logic [0:31] wdata_0, wdata_1;
  logic        ack_0, ack_1;
  logic [0:31] rdata_0, rdata_1;
  logic        rvalid_0, rvalid_1;
  logic        err_0, err_1;
  logic        bram_en;
  logic [0:3]  bram_wen;
  logic [0:31] bram_addr;
  logic [0:31] bram_dout;
  logic [0:31] bram_din;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] mem [0:4095];

  bram_port_arbiter dut (
    .BRAM_Clk  (clk),
    .BRAM_Rst_N(rst_n),
    .Req_0     (req_0),
    .Req_1     (req_1),
    .Addr_0    (addr_0),
    .Addr_1    (addr_1),
    .We_0      (we_0),
    .We_1      (we_1),
    .Wdata_0   (wdata_0),
    .Wdata_1   (wdata_1),
    .Ack_0     (ack_0),
    .Ack_1     (ack_1),
    .Rdata_0   (rdata_0),
    .Rdata_1   (rdata_1),
    .Rvalid_0  (rvalid_0),
    .Rvalid_1  (rvalid_1),
    .Err_0     (err_0),
    .Err_1     (err_1),
    .BRAM_EN   (bram_en),
    .BRAM_WEN  (bram_wen),
    .BRAM_Addr (bram_addr),
    .BRAM_Dout (bram_dout),
    .BRAM_Din  (bram_din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed BRAM of 0x4000 bytes; upper address bits alias. Byte lane 0 is the MSB.
  always @(posedge clk) begin
    logic [31:0] wd;
    int          idx;
    if (bram_en) begin
      idx = int'((32'(bram_addr) >> 2) & 32'hFFF);
      wd  = bram_dout;
      for (int i = 0; i < 4; i++)
        if (bram_wen[i]) mem[idx][31-8*i -: 8] <= wd[31-8*i -: 8];
      bram_din <= mem[idx];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req_0 = 1'b0; req_1 = 1'b0;
    we_0  = '0;   we_1  = '0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    mem[0]    = 32'hCAFEF00D;
    mem[4]    = 32'hDEADBEEF;
    mem[8]    = 32'hAABBCCDD;
    bram_din  = '0;
    addr_0 = '0; addr_1 = '0; wdata_0 = '0; wdata_1 = '0;
    idle_inputs();

    // Reset values, and Ack gated while in reset.
    rst_n = 1'b0;
    req_0 = 1'b1;
    @(negedge clk);
    check("rst_ack0",   32'(ack_0),     32'h0);
    check("rst_en",     32'(bram_en),   32'h0);
    check("rst_wen",    32'(bram_wen),  32'h0);
    check("rst_addr",   32'(bram_addr), 32'h0);
    check("rst_dout",   32'(bram_dout), 32'h0);
    check("rst_rvalid", 32'({rvalid_0, rvalid_1, err_0, err_1}), 32'h0);
    check("rst_rdata0", 32'(rdata_0),   32'h0);
    check("rst_rdata1", 32'(rdata_1),   32'h0);
    req_0 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from requester 0, unaligned-free address 0x10.
    cyc();
    req_0 = 1'b1; addr_0 = 32'h10; we_0 = 4'b0000;
    @(negedge clk);
    check("rd_ack0", 32'(ack_0), 32'h1);
    check("rd_ack1", 32'(ack_1), 32'h0);
    cyc();
    req_0 = 1'b0;
    @(negedge clk);
    check("rd_en",   32'(bram_en),   32'h1);
    check("rd_addr", 32'(bram_addr), 32'h10);
    check("rd_wen",  32'(bram_wen),  32'h0);
    cyc();
    @(negedge clk);
    check("rd_rvalid0", 32'(rvalid_0), 32'h1);
    check("rd_rvalid1", 32'(rvalid_1), 32'h0);
    check("rd_rdata0",  32'(rdata_0),  32'hDEADBEEF);
    cyc();
    @(negedge clk);
    check("rd_rvalid0_end", 32'(rvalid_0), 32'h0);
    check("rd_rdata0_hold", 32'(rdata_0),  32'hDEADBEEF);
    check("rd_en_idle",     32'(bram_en),  32'h0);

    // Byte-lane write from requester 1.
    cyc();
    req_1 = 1'b1; addr_1 = 32'h20; we_1 = 4'b1000; wdata_1 = 32'h11223344;
    @(negedge clk);
    check("wr_ack1", 32'(ack_1), 32'h1);
    cyc();
    req_1 = 1'b0; we_1 = '0;
    @(negedge clk);
    check("wr_en",   32'(bram_en),   32'h1);
    check("wr_wen",  32'(bram_wen),  32'h8);
    check("wr_dout", 32'(bram_dout), 32'h11223344);
    check("wr_addr", 32'(bram_addr), 32'h20);
    cyc();
    @(negedge clk);
    check("wr_no_rvalid", 32'({rvalid_0, rvalid_1}), 32'h0);

    // Read back through an unaligned address; low bits must be dropped.
    cyc();
    req_0 = 1'b1; addr_0 = 32'h22;
    @(negedge clk);
    check("rb_ack0", 32'(ack_0), 32'h1);
    cyc();
    req_0 = 1'b0;
    @(negedge clk);
    check("rb_addr", 32'(bram_addr), 32'h20);
    cyc();
    @(negedge clk);
    check("rb_rvalid0", 32'(rvalid_0), 32'h1);
    check("rb_rdata0",  32'(rdata_0),  32'h11BBCCDD);

    // Both requesters held after reset: grants alternate 0,1,0,1 and data returns to its owner.
    apply_reset();
    addr_0 = 32'h10; addr_1 = 32'h20;
    cyc();
    for (int i = 0; i < 6; i++) begin
      req_0 = (i < 4);
      req_1 = (i < 4);
      @(negedge clk);
      check($sformatf("rr_ack0_%0d", i), 32'(ack_0), 32'((i < 4) && (i % 2 == 0)));
      check($sformatf("rr_ack1_%0d", i), 32'(ack_1), 32'((i < 4) && (i % 2 == 1)));
      check($sformatf("rr_rv0_%0d", i), 32'(rvalid_0), 32'((i >= 2) && (i % 2 == 0)));
      check($sformatf("rr_rv1_%0d", i), 32'(rvalid_1), 32'((i >= 2) && (i % 2 == 1)));
      if (i >= 2 && i % 2 == 0) check($sformatf("rr_rd0_%0d", i), 32'(rdata_0), 32'hDEADBEEF);
      if (i >= 2 && i % 2 == 1) check($sformatf("rr_rd1_%0d", i), 32'(rdata_1), 32'h11BBCCDD);
      cyc();
    end
    idle_inputs();

    // Access at 0x4003, at/above the memory size.
    req_0 = 1'b1; addr_0 = 32'h4003;
    @(negedge clk);
    check("oor_ack0", 32'(ack_0), 32'h1);
    cyc();
    req_0 = 1'b0;
    @(negedge clk);
`ifdef BRAM_ARB_RANGE_CHECK_EN
    check("oor_en", 32'(bram_en), 32'h0);
`else
    check("oor_en",   32'(bram_en),   32'h1);
    check("oor_addr", 32'(bram_addr), 32'h4000);
`endif
    cyc();
    @(negedge clk);
    check("oor_rvalid0", 32'(rvalid_0), 32'h1);
`ifdef BRAM_ARB_RANGE_CHECK_EN
    check("oor_err0",   32'(err_0),   32'h1);
    check("oor_rdata0", 32'(rdata_0), 32'h0);
`else
    check("oor_err0",   32'(err_0),   32'h0);
    check("oor_rdata0", 32'(rdata_0), 32'hCAFEF00D);
`endif
    check("oor_err1", 32'(err_1), 32'h0);

    // Reset pulse right after a read grant discards it and restores the tie-break.
    cyc();
    req_0 = 1'b1; addr_0 = 32'h10;
    @(negedge clk);
    check("mr_ack0", 32'(ack_0), 32'h1);
    cyc();
    req_0 = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("mr_en",     32'(bram_en),   32'h0);
    check("mr_addr",   32'(bram_addr), 32'h0);
    check("mr_dout",   32'(bram_dout), 32'h0);
    check("mr_rdata0", 32'(rdata_0),   32'h0);
    cyc();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("mr_no_rvalid_%0d", i), 32'({rvalid_0, rvalid_1}), 32'h0);
      cyc();
    end
    req_0 = 1'b1; req_1 = 1'b1;
    @(negedge clk);
    check("mr_tie_ack0", 32'(ack_0), 32'h1);
    check("mr_tie_ack1", 32'(ack_1), 32'h0);
    cyc();
    idle_inputs();
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bram_port_arbiter.md
BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

Interface
REQ-001 The block SHALL have one clock (BRAM_Clk); reset is asynchronous and active-low (BRAM_Rst_N).
REQ-002 Parameter C_MEMSIZE, default 'h4000: size of the BRAM in bytes.
REQ-003 Parameter C_PORT_AWIDTH, default 32: byte-address width.
REQ-004 Parameter C_PORT_DWIDTH, default 32: data width.
REQ-005 Parameter C_NUM_WE, default 4: byte write enables per word.
REQ-006 Port BRAM_Clk, in, 1: clock for all state.
REQ-007 Port BRAM_Rst_N, in, 1: asynchronous active-low reset.
REQ-008 Ports Req_0 and Req_1, in, 1 each: access request, held until acknowledged.
REQ-009 Ports Addr_0 and Addr_1, in, [0:C_PORT_AWIDTH-1] each: byte address, with bit 0 as MSB.
REQ-010 Ports We_0 and We_1, in, [0:C_NUM_WE-1] each: byte enables; all zero means a read.
REQ-011 Ports Wdata_0 and Wdata_1, in, [0:C_PORT_DWIDTH-1] each: write data.
REQ-012 Ports Ack_0 and Ack_1, out, 1 each: request accepted this cycle.
REQ-013 Ports Rdata_0 and Rdata_1, out, [0:C_PORT_DWIDTH-1] each: read data.
REQ-014 Ports Rvalid_0 and Rvalid_1, out, 1 each: Rdata is valid, one-cycle pulse.
REQ-015 Ports Err_0 and Err_1, out, 1 each: out-of-range access, one-cycle pulse; only meaningful when BRAM_ARB_RANGE_CHECK_EN is defined.
REQ-016 Port BRAM_EN, out, 1: BRAM port enable.
REQ-017 Port BRAM_WEN, out, [0:C_NUM_WE-1]: BRAM byte write enables.
REQ-018 Port BRAM_Addr, out, [0:C_PORT_AWIDTH-1]: BRAM byte address.
REQ-019 Port BRAM_Dout, out, [0:C_PORT_DWIDTH-1]: write data to the BRAM.
REQ-020 Port BRAM_Din, in, [0:C_PORT_DWIDTH-1]: read data from the BRAM, valid one cycle after BRAM_EN.

Function
REQ-021 Ack_n SHALL be combinational, equal to Req_n AND grant_n; a handshake completes in a cycle where Req_n and Ack_n are both high.
REQ-022 Requests: at most one grant per cycle; a single requester is always granted; the block SHALL accept back-to-back requests, one per cycle.
REQ-023 Arbitration: when both request, the requester not granted last SHALL win (round-robin); the last-granted pointer SHALL update only on a grant.
REQ-024 Command stage: in cycle t+1 after a grant in cycle t, BRAM_EN=1, and BRAM_Addr, BRAM_WEN and BRAM_Dout SHALL be registered copies of the granted inputs; with no grant, BRAM_EN=0 and BRAM_WEN=0.
REQ-025 BRAM_Addr SHALL carry the low two bits forced to 00 (word-aligned).
REQ-026 Reads: for a read granted in cycle t, Rvalid_n=1 in cycle t+2 with Rdata_n=BRAM_Din; the other requester's Rvalid stays 0.
REQ-027 Writes SHALL produce no Rvalid pulse.
REQ-028 Data holding: Rdata_n SHALL hold its last value when Rvalid_n=0.
REQ-029 Tags: a 2-entry pipeline of requester ID and read flag SHALL route each return to the correct requester; reads from both requesters interleaved on alternate cycles SHALL return in issue order.

Reset
REQ-030 On BRAM_Rst_N=0, asynchronously: BRAM_EN=0, BRAM_WEN=0, BRAM_Addr=0, BRAM_Dout=0, Rvalid_n=0, Err_n=0, Rdata_n=0, and the last-granted pointer=1 (requester 0 wins the first tie).
REQ-031 Reset asserted mid-access SHALL discard in-flight reads: no Rvalid after reset release.
REQ-032 Ack_n SHALL be 0 while reset is asserted.

Configuration
REQ-033 With BRAM_ARB_RANGE_CHECK_EN defined: a granted access with Addr >= C_MEMSIZE SHALL be acknowledged but not issued (BRAM_EN=0 in t+1), and SHALL produce Err_n=1 in t+2; a read additionally gives Rvalid_n=1 with Rdata_n=0 in t+2.
REQ-034 Without BRAM_ARB_RANGE_CHECK_EN: the address SHALL pass through unchecked (the BRAM aliases the upper bits), and Err_n SHALL be tied to 0.

Verification
REQ-035 Req_0 read, Addr=0x10, memory word 0x10=0xDEADBEEF -> Ack_0 in t, BRAM_EN=1 with BRAM_Addr=0x10 in t+1, Rvalid_0=1 with Rdata_0=0xDEADBEEF in t+2.
REQ-036 Req_0 and Req_1 held high together for 4 cycles after reset -> grants in the order 0,1,0,1; read data returns to the matching requester.
REQ-037 Req_1 write, We=1000, Addr=0x20, Wdata=0x11223344 -> BRAM_WEN=1000 and BRAM_Dout=0x11223344 in t+1; a later read of 0x20 shows byte 0 =0x11 and the other bytes unchanged.
REQ-038 Addr=0x4003 read with the macro defined -> no BRAM_EN, Err_0=1, Rvalid_0=1 with Rdata_0=0; without the macro -> BRAM_Addr=0x4000.
REQ-039 BRAM_Rst_N pulsed low in the cycle after a read grant -> no Rvalid afterwards, all outputs at reset values, and the next tie goes to requester 0.
